// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmit path.
// Contents: APB register offsets (word index, paddr[3:2]), STAT/CTRL bit
// positions, and the drain FSM state encoding.
package uart_tx_fifo_pkg;

  // Register offsets as decoded from paddr[3:2]
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  // STAT bit positions (level occupies [DEPTH_LOG2:0])
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_BUSY  = 10;
  localparam int STAT_OVF   = 11;

  // CTRL bit positions
  localparam int CTRL_IE_IDLE = 0;

  // Drain FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// APB slave bus bundle for uart_tx_fifo.
// Handshake: a transfer is in its access phase while psel & penable are
// high; it completes on the rising clock edge where pready is also high.
// Signals: psel, penable, pwrite, paddr[15:0], pwdata[31:0] (master->slave);
// prdata[31:0], pready, pslverr (slave->master).
interface uart_tx_fifo_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO, 2**DEPTH_LOG2 entries.
// Ports: clk, rst (sync, active high), push/wdata, pop, rdata (head,
// combinational), level (DEPTH_LOG2+1 bits), empty, full.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop & ~empty;
  // When full, the slot being freed by a same-cycle pop is the one written.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered APB transmit front end for the UartTx byte serialiser.
// Ports: clk, rst (sync, active high); apbs (APB slave bundle);
// tx_data/tx_we/tx_ready (UartTx handshake); irq (level, idle interrupt);
// dreq (DMA request, FIFO not full); dbg_state (drain FSM state).
// Build option: UART_TX_FIFO_DROP_EN -- when defined, a DATA write while the
// FIFO is full completes immediately, drops the byte and sets sticky STAT.ovf
// (W1C on STAT[11]); otherwise such a write is stalled until an entry frees.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_fifo_if.slave        apbs,
  output logic [7:0]           tx_data,
  output logic                 tx_we,
  input  logic                 tx_ready,
  output logic                 irq,
  output logic                 dreq,
  output drain_state_t         dbg_state
);
  logic                access;
  logic [1:0]          addr;
  logic                data_wr;
  logic                ctrl_wr;
  logic                fifo_push;
  logic                fifo_pop;
  logic [7:0]          fifo_head;
  logic [DEPTH_LOG2:0] level;
  logic                empty;
  logic                full;
  logic                ie_idle;
  logic                ovf;
  logic                busy;
  drain_state_t        state;
  drain_state_t        state_nxt;
  logic                unused_bits;

  assign access  = apbs.psel & apbs.penable;
  assign addr    = apbs.paddr[3:2];
  assign data_wr = access & apbs.pwrite & (addr == ADDR_DATA);
  assign ctrl_wr = access & apbs.pwrite & (addr == ADDR_CTRL);
  assign apbs.pslverr = 1'b0;
  assign unused_bits  = ^{apbs.paddr[15:4], apbs.paddr[1:0], apbs.pwdata[31:8]};

`ifdef UART_TX_FIFO_DROP_EN
  logic stat_wr;
  logic ovf_set;

  assign apbs.pready = 1'b1;
  assign fifo_push   = data_wr & ~full;
  assign ovf_set     = data_wr & full;
  assign stat_wr     = access & apbs.pwrite & (addr == ADDR_STAT);

  // Sticky overflow; a same-cycle set beats the W1C clear.
  always_ff @(posedge clk) begin
    if (rst)                                  ovf <= 1'b0;
    else if (ovf_set)                         ovf <= 1'b1;
    else if (stat_wr && apbs.pwdata[STAT_OVF]) ovf <= 1'b0;
  end
`else
  // A stalled DATA write completes in the cycle the drain frees a slot.
  assign apbs.pready = ~(data_wr & full) | fifo_pop;
  assign fifo_push   = data_wr & apbs.pready;
  assign ovf         = 1'b0;
`endif

  uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (apbs.pwdata[7:0]),
    .rdata (fifo_head),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  // Drain FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Drain FSM: next state. Launch only while UartTx reports idle; stay in
  // SEND until it has dropped READY, which marks the byte as taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (tx_ready && !empty) state_nxt = ST_SEND;
      ST_SEND: if (!tx_ready)          state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drain FSM: outputs. tx_we is high exactly while in SEND.
  always_comb begin
    fifo_pop = (state == ST_IDLE) & tx_ready & ~empty;
    tx_we    = (state == ST_SEND);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst)           tx_data <= '0;
    else if (fifo_pop) tx_data <= fifo_head;
  end

  always_ff @(posedge clk) begin
    if (rst)          ie_idle <= 1'b0;
    else if (ctrl_wr) ie_idle <= apbs.pwdata[CTRL_IE_IDLE];
  end

  assign busy = ~empty | (state != ST_IDLE) | ~tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq  <= 1'b0;
      dreq <= 1'b1;
    end else begin
      irq  <= ie_idle & ~busy;
      dreq <= ~full;
    end
  end

  always_comb begin
    apbs.prdata = '0;
    if (access) begin
      case (addr)
        ADDR_STAT: begin
          apbs.prdata[DEPTH_LOG2:0] = level;
          apbs.prdata[STAT_EMPTY]   = empty;
          apbs.prdata[STAT_FULL]    = full;
          apbs.prdata[STAT_BUSY]    = busy;
          apbs.prdata[STAT_OVF]     = ovf;
        end
        ADDR_CTRL: apbs.prdata[CTRL_IE_IDLE] = ie_idle;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a randomized
// write stream, with a behavioural UartTx model feeding a byte scoreboard.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam logic [15:0] A_DATA = 16'h0;
  localparam logic [15:0] A_STAT = 16'h4;
  localparam logic [15:0] A_CTRL = 16'h8;
  localparam logic [15:0] A_RSVD = 16'hC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   tx_data;
  logic         tx_we;
  logic         tx_ready = 1'b1;
  logic         irq;
  logic         dreq;
  drain_state_t dbg_state;

  uart_tx_fifo_if apbs_if ();

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst       (rst),
    .apbs      (apbs_if.slave),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_ready  (tx_ready),
    .irq       (irq),
    .dreq      (dreq),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- UartTx model ----------------
  // READY falls for ready_len cycles after each accepted WE. hold_low forces
  // READY low; no_ack keeps READY high but never takes the byte.
  logic hold_low = 1'b0;
  logic no_ack   = 1'b0;
  logic rand_len = 1'b0;
  int   busy_cnt = 0;
  int   cap_cnt  = 0;
  int   rise_cnt = 0;
  logic we_d     = 1'b0;

  always @(negedge clk) begin
    if (tx_we === 1'b1 && we_d === 1'b0) rise_cnt++;
    we_d = tx_we;
    if (busy_cnt > 0) busy_cnt--;
    if (tx_we === 1'b1 && tx_ready && !no_ack) begin
      cap_cnt++;
      check("tx_byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("tx_byte_order", tx_data, exp_q.pop_front());
      busy_cnt = rand_len ? int'($urandom_range(1, 25)) : 20;
    end
    tx_ready = !hold_low && (busy_cnt == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int waits);
    @(negedge clk);
    apbs_if.psel    = 1'b1;
    apbs_if.penable = 1'b0;
    apbs_if.pwrite  = wr;
    apbs_if.paddr   = addr;
    apbs_if.pwdata  = wdata;
    @(negedge clk);
    apbs_if.penable = 1'b1;
    waits = 0;
    #4;
    while (apbs_if.pready !== 1'b1 && waits < 500) begin
      @(negedge clk);
      #4;
      waits++;
    end
    check("apb_completes", waits < 500, 1);
    check("apb_pslverr", apbs_if.pslverr, 0);
    rdata = apbs_if.prdata;
    @(posedge clk);
    #1;
    apbs_if.psel    = 1'b0;
    apbs_if.penable = 1'b0;
    apbs_if.pwrite  = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] addr, input logic [31:0] wdata, output int waits);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, wdata, dummy, waits);
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [31:0] rdata, output int waits);
    apb_xfer(1'b0, addr, 32'h0, rdata, waits);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && tx_ready === 1'b1 && tx_we === 1'b0 && dbg_state == ST_IDLE)
           && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, n < 3000, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int          w;
    int          cap0, rise0, n;
    logic [7:0]  b;
    logic [7:0]  t1_bytes [3];

    apbs_if.psel = 1'b0; apbs_if.penable = 1'b0; apbs_if.pwrite = 1'b0;
    apbs_if.paddr = '0;  apbs_if.pwdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_we", tx_we, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_irq", irq, 0);
    check("rst_dreq", dreq, 1);
    check("rst_prdata", apbs_if.prdata, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    apb_read(A_STAT, rd, w);
    check("rst_level", rd[DL:0], 0);
    check("rst_empty", rd[STAT_EMPTY], 1);
    check("rst_full", rd[STAT_FULL], 0);
    check("rst_ovf", rd[STAT_OVF], 0);
    apb_read(A_CTRL, rd, w);
    check("rst_ctrl", rd, 0);

    // 1: three back-to-back bytes, in order, one WE pulse each
    cap0 = cap_cnt; rise0 = rise_cnt;
    t1_bytes = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(t1_bytes[i]);
      apb_write(A_DATA, {24'h0, t1_bytes[i]}, w);
      check("t1_pready_immediate", w, 0);
    end
    apb_read(A_STAT, rd, w);
    check("t1_level_peak", (rd[DL:0] == 2) || (rd[DL:0] == 3), 1);
    wait_drain("t1_drain");
    check("t1_bytes_sent", cap_cnt - cap0, 3);
    check("t1_we_pulses", rise_cnt - rise0, 3);

    // 3: idle interrupt
    check("t3_irq_off_ctrl0", irq, 0);
    apb_write(A_CTRL, 32'h1, w);
    repeat (2) @(posedge clk);
    #1;
    check("t3_irq_idle", irq, 1);
    exp_q.push_back(8'h77);
    apb_write(A_DATA, 32'h77, w);
    repeat (2) @(posedge clk);
    #1;
    check("t3_irq_drops", irq, 0);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t3_irq_returns", n < 200, 1);
    check("t3_irq_after_char", n >= 20, 1);
    check("t3_irq_ready_high", tx_ready, 1);
    check("t3_irq_fifo_empty", exp_q.size(), 0);
    apb_read(A_STAT, rd, w);
    check("t3_stat_empty", rd[STAT_EMPTY], 1);
    apb_write(A_CTRL, 32'h0, w);

    // 2/4: fill with READY held low, then write while full
    wait_drain("t2_predrain");
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      apb_write(A_DATA, {24'h0, b}, w);
      check("t2_fill_pready", w, 0);
    end
    apb_read(A_STAT, rd, w);
    check("t2_level_full", rd[DL:0], DEPTH);
    check("t2_full", rd[STAT_FULL], 1);
    check("t2_not_empty", rd[STAT_EMPTY], 0);
    check("t2_dreq_low", dreq, 0);
`ifdef UART_TX_FIFO_DROP_EN
    apb_write(A_DATA, 32'h55, w);
    check("t2_drop_pready", w, 0);
    apb_read(A_STAT, rd, w);
    check("t2_ovf_set", rd[STAT_OVF], 1);
    check("t2_drop_level", rd[DL:0], DEPTH);
    apb_write(A_STAT, 32'h800, w);
    apb_read(A_STAT, rd, w);
    check("t2_ovf_w1c", rd[STAT_OVF], 0);
    hold_low = 1'b0;
`else
    exp_q.push_back(8'h55);
    fork
      apb_write(A_DATA, 32'h55, w);
      begin
        repeat (10) @(posedge clk);
        #1;
        check("t2_stall_pready", apbs_if.pready, 0);
        hold_low = 1'b0;
      end
    join
    check("t2_write_stalled", w > 0, 1);
    apb_read(A_STAT, rd, w);
    check("t4_level_stays_full", rd[DL:0], DEPTH);
    check("t4_full", rd[STAT_FULL], 1);
    check("t2_ovf_zero", rd[STAT_OVF], 0);
`endif
    wait_drain("t2_drain");
    check("t2_dreq_back", dreq, 1);

    // 6: reserved offset and DATA read back zero
    apb_read(A_RSVD, rd, w);
    check("t6_rsvd_zero", rd, 0);
    check("t6_rsvd_pready", w, 0);
    apb_read(A_DATA, rd, w);
    check("t6_data_zero", rd, 0);
    check("t6_data_pready", w, 0);
    apb_write(A_RSVD, 32'hFFFF_FFFF, w);
    apb_read(A_CTRL, rd, w);
    check("t6_rsvd_write_ignored", rd, 0);

    // 5: reset while SEND with 4 bytes queued
    apb_write(A_CTRL, 32'h1, w);
    no_ack = 1'b1;
    for (int i = 0; i < 5; i++) apb_write(A_DATA, {24'h0, 8'($urandom_range(0, 255))}, w);
    apb_read(A_STAT, rd, w);
    check("t5_level_queued", rd[DL:0], 4);
    check("t5_in_send", dbg_state, ST_SEND);
    check("t5_we_held", tx_we, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_we_cleared", tx_we, 0);
    check("t5_irq_cleared", irq, 0);
    check("t5_dreq_set", dreq, 1);
    check("t5_state_idle", dbg_state, ST_IDLE);
    apb_read(A_STAT, rd, w);
    check("t5_level_zero", rd[DL:0], 0);
    apb_read(A_CTRL, rd, w);
    check("t5_ctrl_zero", rd, 0);
    no_ack = 1'b0;
    rise0 = rise_cnt;
    repeat (50) @(negedge clk);
    check("t5_no_relaunch", rise_cnt - rise0, 0);

    // Randomized write stream against random UartTx character times
    rand_len = 1'b1;
    cap0 = cap_cnt; rise0 = rise_cnt;
    for (int i = 0; i < 60; i++) begin
      b = 8'($urandom_range(0, 255));
`ifdef UART_TX_FIFO_DROP_EN
      apb_read(A_STAT, rd, w);
      if (!rd[STAT_FULL]) begin
        exp_q.push_back(b);
        apb_write(A_DATA, {24'h0, b}, w);
      end
`else
      exp_q.push_back(b);
      apb_write(A_DATA, {24'h0, b}, w);
`endif
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_drain("rand_drain");
    check("rand_we_per_byte", rise_cnt - rise0, cap_cnt - cap0);
    apb_read(A_STAT, rd, w);
    check("rand_end_empty", rd[STAT_EMPTY], 1);
    check("rand_end_dreq", dreq, 1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
